// File: rtl/dma_w_arb_if.sv
// dma_w_arb_if: requester-side and engine-side signals of the write-DMA arbiter.
// master = requesters/engine side, slave = arbiter side.
interface dma_w_arb_if #(parameter int NREQ = 4);
  localparam int IDW = $clog2(NREQ);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_done;
  logic [NREQ*32-1:0] req_src_sa;
  logic [NREQ*32-1:0] req_dst_sa;
  logic [NREQ*32-1:0] req_len;
  logic               eng_cfg_valid;
  logic               eng_cfg_ready;
  logic [31:0]        eng_src_sa;
  logic [31:0]        eng_dst_sa;
  logic [31:0]        eng_len;
  logic               busy;
  logic [IDW-1:0]     cur_id;
  modport master (
    output req_valid, req_src_sa, req_dst_sa, req_len, eng_cfg_ready,
    input  req_ready, req_done, eng_cfg_valid, eng_src_sa, eng_dst_sa, eng_len, busy, cur_id
  );
  modport slave (
    input  req_valid, req_src_sa, req_dst_sa, req_len, eng_cfg_ready,
    output req_ready, req_done, eng_cfg_valid, eng_src_sa, eng_dst_sa, eng_len, busy, cur_id
  );
endinterface

// File: rtl/dma_w_arb.sv
// dma_w_arb: round-robin arbiter feeding requests to a DMA write engine as segments.
// Define DMA_W_ARB_SPLIT_EN to split segments at SEG_MAX destination boundaries.
module dma_w_arb #(
  parameter int NREQ      = 4,
  parameter int AXI_BYTES = 16,
  parameter int SEG_MAX   = 4096
) (
  input logic          usr_clk,
  input logic          usr_reset_n,
  dma_w_arb_if.slave   bus
);
  localparam int IDW = $clog2(NREQ);
  localparam logic [31:0] AMASK = ~(32'(AXI_BYTES) - 32'd1);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d, cur_id_q, cur_id_d, win, cand;
  logic [31:0]     src_q, src_d, dst_q, dst_d, len_q, len_d, seg_len, win_len;
  logic [NREQ-1:0] ready, done;
  logic            any, cfg_valid;
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (bus.req_valid[cand]) begin
        win = cand;
        any = 1'b1;
      end
    end
  end
`ifdef DMA_W_ARB_SPLIT_EN
  logic [32:0] room;
  assign room    = 33'(SEG_MAX) - ({1'b0, dst_q} & 33'(SEG_MAX - 1));
  assign seg_len = ({1'b0, len_q} < room) ? len_q : room[31:0];
`else
  assign seg_len = len_q;
`endif
  assign win_len = bus.req_len[32*win +: 32] & AMASK;
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cur_id_d  = cur_id_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    ready     = '0;
    done      = '0;
    cfg_valid = 1'b0;
    case (state_q)
      IDLE: if (any) begin
        ready[win] = 1'b1;
        cur_id_d   = win;
        rr_ptr_d   = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
        src_d      = bus.req_src_sa[32*win +: 32] & AMASK;
        dst_d      = bus.req_dst_sa[32*win +: 32] & AMASK;
        len_d      = win_len;
        state_d    = (win_len == 32'd0) ? DONE : ISSUE;
      end
      ISSUE: begin
        cfg_valid = 1'b1;
        if (bus.eng_cfg_ready) begin
          src_d = src_q + seg_len;
          dst_d = dst_q + seg_len;
          len_d = len_q - seg_len;
          if (len_q == seg_len) begin
            done[cur_id_q] = 1'b1;
            state_d        = IDLE;
          end
        end
      end
      DONE: begin
        done[cur_id_q] = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      cur_id_q <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cur_id_q <= cur_id_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
    end
  end
  assign bus.req_ready     = ready;
  assign bus.req_done      = done;
  assign bus.eng_cfg_valid = cfg_valid;
  assign bus.eng_src_sa    = src_q;
  assign bus.eng_dst_sa    = dst_q;
  assign bus.eng_len       = seg_len;
  assign bus.busy          = (state_q != IDLE);
  assign bus.cur_id        = cur_id_q;
endmodule
